// File: rtl/axi_sram_slave.sv
// AXI3 responder over a 2^ADDR_WIDTH x 32-bit word array; one outstanding burst per direction.
// Latency: AR accept -> first rvalid 1 cycle, last W beat -> bvalid 1 cycle (+READ_LAT/WRITE_LAT with AXI_SLAVE_LATENCY_EN).
// Backpressure: R beats and B hold stable until rready/bready; AR/AW/W are refused while an engine is busy.
module axi_sram_slave #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned READ_LAT   = 2,
  parameter int unsigned WRITE_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  // read address channel
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  // read data channel
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // write address channel
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  // write data channel
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // write response channel
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned DEPTH       = 1 << ADDR_WIDTH;
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_e;

  logic [31:0] mem [DEPTH];

  // Only the bits above the word index select the window.
  function automatic logic addr_hit(input logic [31:0] a);
    return a[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2];
  endfunction

  // Protection/cache/lock attributes, the upper length bits and wid carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{arlock, arcache, arprot, arlen[7:4],
                       awlock, awcache, awprot, awlen[7:4], wid};

  // ---------------- read engine ----------------
  r_state_e    r_state_q, r_state_d;
  logic [3:0]  rid_q, rid_d;
  logic [31:0] raddr_q, raddr_d, raddr_next, rlook;
  logic [3:0]  rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic [2:0]  rsize_q, rsize_d;
  logic [1:0]  rburst_q, rburst_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rload;
`ifdef AXI_SLAVE_LATENCY_EN
  logic [7:0]  rwait_q, rwait_d;
`endif

  assign arready    = (r_state_q == R_IDLE) && !rst;
  assign rvalid     = (r_state_q == R_DATA);
  assign rlast      = rvalid && (rbeat_q == rlen_q);
  assign rid        = rid_q;
  assign rdata      = rdata_q;
  assign rresp      = rresp_q;
  assign raddr_next = (rburst_q == BURST_FIXED) ? raddr_q : raddr_q + (32'd1 << rsize_q);

  // Read next-state: accept AR, optionally wait, then stream beats with the next word prefetched on each handshake.
  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rbeat_d   = rbeat_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rload     = 1'b0;
    rlook     = raddr_next;
`ifdef AXI_SLAVE_LATENCY_EN
    rwait_d   = rwait_q;
`endif
    case (r_state_q)
      R_IDLE: begin
        if (arvalid && arready) begin
          rid_d     = arid;
          raddr_d   = araddr;
          rlen_d    = arlen[3:0];
          rsize_d   = arsize;
          rburst_d  = arburst;
          rbeat_d   = '0;
          rlook     = araddr;
          rload     = 1'b1;
          r_state_d = R_DATA;
`ifdef AXI_SLAVE_LATENCY_EN
          rwait_d   = '0;
          if (READ_LAT != 0) r_state_d = R_WAIT;
`endif
        end
      end
`ifdef AXI_SLAVE_LATENCY_EN
      R_WAIT: begin
        if (rwait_q == 8'(READ_LAT - 1)) r_state_d = R_DATA;
        else                             rwait_d   = rwait_q + 8'd1;
      end
`endif
      R_DATA: begin
        if (rready) begin
          if (rbeat_q == rlen_q) begin
            r_state_d = R_IDLE;
          end else begin
            raddr_d = raddr_next;
            rbeat_d = rbeat_q + 4'd1;
            rload   = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    // The read register samples the array before any same-edge write lands (read-old).
    if (rload) begin
      rdata_d = addr_hit(rlook) ? mem[rlook[ADDR_WIDTH+1:2]] : '0;
      rresp_d = addr_hit(rlook) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Read state and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rbeat_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
`ifdef AXI_SLAVE_LATENCY_EN
      rwait_q   <= '0;
`endif
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rbeat_q   <= rbeat_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
`ifdef AXI_SLAVE_LATENCY_EN
      rwait_q   <= rwait_d;
`endif
    end
  end

  // ---------------- write engine ----------------
  w_state_e    w_state_q, w_state_d;
  logic [3:0]  bid_q, bid_d;
  logic [31:0] waddr_q, waddr_d, waddr_next;
  logic [3:0]  wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic [2:0]  wsize_q, wsize_d;
  logic [1:0]  wburst_q, wburst_d;
  logic        werr_q, werr_d, werr_now;
  logic [1:0]  bresp_q, bresp_d;
  logic        mem_we;
`ifdef AXI_SLAVE_LATENCY_EN
  logic [7:0]  wwait_q, wwait_d;
`endif

  assign awready    = (w_state_q == W_IDLE) && !rst;
  assign wready     = (w_state_q == W_DATA);
  assign bvalid     = (w_state_q == W_RESP);
  assign bid        = bid_q;
  assign bresp      = bresp_q;
  assign waddr_next = (wburst_q == BURST_FIXED) ? waddr_q : waddr_q + (32'd1 << wsize_q);
  assign mem_we     = (w_state_q == W_DATA) && wvalid && addr_hit(waddr_q);
  // A miss or a wlast that disagrees with the beat count poisons the response but never stalls the burst.
  assign werr_now   = werr_q || !addr_hit(waddr_q) || (wlast != (wbeat_q == wlen_q));

  // Write next-state: accept AW, count W beats against awlen, optionally wait, then hold B until bready.
  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    wbeat_d   = wbeat_q;
    werr_d    = werr_q;
    bresp_d   = bresp_q;
`ifdef AXI_SLAVE_LATENCY_EN
    wwait_d   = wwait_q;
`endif
    case (w_state_q)
      W_IDLE: begin
        if (awvalid && awready) begin
          bid_d     = awid;
          waddr_d   = awaddr;
          wlen_d    = awlen[3:0];
          wsize_d   = awsize;
          wburst_d  = awburst;
          wbeat_d   = '0;
          werr_d    = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          if (wbeat_q == wlen_q) begin
            bresp_d   = werr_now ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
`ifdef AXI_SLAVE_LATENCY_EN
            wwait_d   = '0;
            if (WRITE_LAT != 0) w_state_d = W_WAIT;
`endif
          end else begin
            werr_d  = werr_now;
            wbeat_d = wbeat_q + 4'd1;
            waddr_d = waddr_next;
          end
        end
      end
`ifdef AXI_SLAVE_LATENCY_EN
      W_WAIT: begin
        if (wwait_q == 8'(WRITE_LAT - 1)) w_state_d = W_RESP;
        else                              wwait_d   = wwait_q + 8'd1;
      end
`endif
      W_RESP: begin
        if (bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      bid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      wbeat_q   <= '0;
      werr_q    <= 1'b0;
      bresp_q   <= '0;
`ifdef AXI_SLAVE_LATENCY_EN
      wwait_q   <= '0;
`endif
    end else begin
      w_state_q <= w_state_d;
      bid_q     <= bid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      wbeat_q   <= wbeat_d;
      werr_q    <= werr_d;
      bresp_q   <= bresp_d;
`ifdef AXI_SLAVE_LATENCY_EN
      wwait_q   <= wwait_d;
`endif
    end
  end

  // Byte-lane writes into the array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr_q[ADDR_WIDTH+1:2]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule
